// File: rtl/tb_pkg.sv
// Definitions shared by the result monitor and the stimulus driver: FSM one-hot encodings
// and the delay code that means "latency not measured yet". Declarations only, no logic.
package tb_pkg;

   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_ARM  = 4'b0010,
      ST_RUN  = 4'b0100,
      ST_DONE = 4'b1000
   } mon_state_t;

   localparam int unsigned DELAY_CODE_K = 4;
   localparam logic [DELAY_CODE_K-1:0] CODE_NOT_MEASURED = '1;

   // All-ones code for an arbitrary code width k.
   function automatic logic [31:0] not_measured_code(input int unsigned k);
      return (32'd1 << k) - 32'd1;
   endfunction

endpackage

// File: rtl/exp_delay_line.sv
// Golden-sum delay line with a valid tag per stage; stage 0 loads one cycle after the operands,
// tap read at sel is combinational. Shifts every cycle, never stalls.
module exp_delay_line #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk_dut,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] delayed_a,
   input  logic [WIDTH-1:0] delayed_b,
   input  logic [SW-1:0]    sel,
   output logic [WIDTH-1:0] tap_dat,
   output logic             tap_vld
);

   logic [WIDTH-1:0] exp_dat [DEPTH];
   logic [DEPTH-1:0] exp_vld;
   logic             tag;

   // An all-zero operand pair is the driver's marker vector and must never be compared.
   assign tag = (delayed_a != '0) || (delayed_b != '0);

   always_ff @(posedge clk_dut) begin
      exp_dat[0] <= delayed_a + delayed_b;
      for (int n = 1; n < DEPTH; n++) begin
         exp_dat[n] <= exp_dat[n-1];
      end
   end

   always_ff @(posedge clk_dut or negedge reset_n) begin
      if (!reset_n) begin
         exp_vld <= '0;
      end else begin
         exp_vld[0] <= tag;
         for (int n = 1; n < DEPTH; n++) begin
            exp_vld[n] <= exp_vld[n-1];
         end
      end
   end

   assign tap_dat = exp_dat[sel];
   assign tap_vld = exp_vld[sel];

endmodule

// File: rtl/monitor.sv
// Compares DUT results against a latency-matched golden sum; all outputs registered, no backpressure.
// Option MONITOR_STOP_ON_ERR_EN: end the run on the cycle after the first mismatch.
module monitor
   import tb_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int K       = 4,
   parameter int DEPTH   = 2**K,
   parameter int OFFSET  = 2,
   parameter int N_TESTS = 1000
) (
   input  logic             clk_dut,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] i_delayed_a,
   input  logic [WIDTH-1:0] i_delayed_b,
   input  logic [WIDTH-1:0] i_dut_out,
   input  logic [WIDTH-1:0] i_dut_delay,
   output logic [31:0]      o_test_count,
   output logic [31:0]      o_err_count,
   output logic             o_done,
   output logic             o_pass,
   output logic [WIDTH-1:0] o_first_err
);

   localparam int          SW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          AW        = $clog2(DEPTH + 1);
   localparam logic [31:0] SAT       = '1;
   localparam logic [31:0] N_TESTS_W = 32'(N_TESTS);

   mon_state_t       state;
   logic [SW-1:0]    sel;
   logic [SW-1:0]    sel_calc;
   logic [AW-1:0]    arm_cnt;
   logic [K-1:0]     code;
   logic             code_valid;
   int               sel_int;
   logic [WIDTH-1:0] tap_dat;
   logic             tap_vld;
   logic             compare;
   logic             mismatch;
   logic [31:0]      test_next;

   assign code       = i_dut_delay[K-1:0];
   assign code_valid = 32'(code) != not_measured_code(K);

   if (WIDTH > K) begin : g_unused
      logic unused_delay_hi;
      assign unused_delay_hi = ^i_dut_delay[WIDTH-1:K];
   end

   // Stage n holds the sum of operands seen n+1 cycles ago, and the operands already
   // lag the driver by OFFSET, so a latency of code cycles lands on stage code-OFFSET-1.
   always_comb begin
      sel_int = int'({1'b0, code}) - OFFSET - 1;
      if (sel_int < 0) begin
         sel_int = 0;
      end else if (sel_int > DEPTH - 1) begin
         sel_int = DEPTH - 1;
      end
      sel_calc = sel_int[SW-1:0];
   end

   exp_delay_line #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_exp (
      .clk_dut   (clk_dut),
      .reset_n   (reset_n),
      .delayed_a (i_delayed_a),
      .delayed_b (i_delayed_b),
      .sel       (sel),
      .tap_dat   (tap_dat),
      .tap_vld   (tap_vld)
   );

   assign compare   = (state == ST_RUN) && tap_vld;
   assign mismatch  = compare && (i_dut_out != tap_dat);
   assign test_next = (o_test_count == SAT) ? SAT : o_test_count + 32'd1;

   always_ff @(posedge clk_dut or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         sel          <= '0;
         arm_cnt      <= '0;
         o_test_count <= '0;
         o_err_count  <= '0;
         o_first_err  <= '0;
         o_done       <= 1'b0;
         o_pass       <= 1'b0;
      end else begin
         o_done <= (state == ST_DONE);
         o_pass <= (state == ST_DONE) && (o_err_count == '0);
         case (state)
            ST_IDLE: begin
               if (code_valid) begin
                  sel     <= sel_calc;
                  arm_cnt <= '0;
                  state   <= ST_ARM;
               end
            end
            ST_ARM: begin
               // Warm-up long enough for every tap to hold a post-reset value.
               if (arm_cnt == AW'(DEPTH - 1)) begin
                  state <= ST_RUN;
               end else begin
                  arm_cnt <= arm_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (compare) begin
                  o_test_count <= test_next;
                  if (mismatch) begin
                     if (o_err_count == '0) begin
                        o_first_err <= i_dut_out;
                     end
                     if (o_err_count != SAT) begin
                        o_err_count <= o_err_count + 32'd1;
                     end
                  end
                  if (test_next == N_TESTS_W) begin
                     state <= ST_DONE;
                  end
`ifdef MONITOR_STOP_ON_ERR_EN
                  if (mismatch) begin
                     state <= ST_DONE;
                  end
`endif
               end
            end
            ST_DONE: state <= ST_DONE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/monitor.md
MONITOR -- requirements
Module: monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-002 SHALL have parameter K, default 4: delay-code width; code value 2^K-1 means "not measured".
REQ-003 SHALL have parameter DEPTH, default 2^K: expected-value delay-line length.
REQ-004 SHALL have parameter OFFSET, default 2: fixed operand pre-delay already applied upstream.
REQ-005 SHALL have parameter N_TESTS, default 1000: number of compares per run.
REQ-006 SHALL have port clk_dut  in  1  sole clock, all logic on its rising edge.
REQ-007 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port i_delayed_a  in  WIDTH  operand A, already delayed by OFFSET cycles.
REQ-009 SHALL have port i_delayed_b  in  WIDTH  operand B, already delayed by OFFSET cycles.
REQ-010 SHALL have port i_dut_out  in  WIDTH  DUT result.
REQ-011 SHALL have port i_dut_delay  in  WIDTH  measured DUT latency; only bits [K-1:0] are used.
REQ-012 SHALL have port o_test_count  out  32  compares performed.
REQ-013 SHALL have port o_err_count  out  32  mismatches found.
REQ-014 SHALL have port o_done  out  1  run finished.
REQ-015 SHALL have port o_pass  out  1  o_done and o_err_count==0.
REQ-016 SHALL have port o_first_err  out  WIDTH  DUT value at the first mismatch.

Function
REQ-017 SHALL compute golden = (i_delayed_a + i_delayed_b) mod 2^WIDTH and register it into exp[0] each cycle; exp[n] <= exp[n-1] for n = 1..DEPTH-1.
REQ-018 SHALL carry a valid tag with each exp entry: tag = 0 when both operands are zero (driver marker vector), 1 otherwise.
REQ-019 SHALL select tap sel = code - OFFSET - 1, clamped to the range [0, DEPTH-1], where code = i_dut_delay[K-1:0].
REQ-020 SHALL implement FSM IDLE -> ARM -> RUN -> DONE.
REQ-021 SHALL move IDLE -> ARM when code != 2^K-1, latching sel at that moment; later changes to i_dut_delay SHALL be ignored.
REQ-022 SHALL stay in ARM for exactly DEPTH cycles (warm-up), then go to RUN.
REQ-023 SHALL, in RUN, compare i_dut_out with exp[sel] each cycle in which tag[sel]=1: increment o_test_count; on mismatch, increment o_err_count.
REQ-024 SHALL, on the first mismatch only, capture i_dut_out into o_first_err.
REQ-025 SHALL go RUN -> DONE in the cycle that o_test_count reaches N_TESTS; DONE is terminal until reset.
REQ-026 SHALL saturate both counters at 2^32-1 (no wrap).
REQ-027 SHALL, on a compare that is both the final (N_TESTS-th) compare and a mismatch, count the error and then enter DONE.
REQ-028 SHALL have registered outputs only; o_done asserts the cycle after entering DONE.

Reset
REQ-029 SHALL, on reset_n low at any time including mid-run, immediately force: FSM=IDLE, counters=0, o_done=0, o_pass=0, o_first_err=0, all tags=0.
REQ-030 SHALL NOT reset the exp data bits; only the tags are reset.

Configuration
REQ-031 SHALL, with MONITOR_STOP_ON_ERR_EN defined, enter DONE on the cycle after the first mismatch.
REQ-032 SHALL, without MONITOR_STOP_ON_ERR_EN, run all N_TESTS compares regardless of errors.

Structure
REQ-033 SHALL place the FSM state encodings (one-hot, 4 bits) and the not-measured code constant in a shared package tb_pkg, shared with the driver.
REQ-034 SHALL implement the delay line and tags as sub-module exp_delay_line (parameters WIDTH, DEPTH; tapped read port sel).

Verification
REQ-035 SHALL be verified for: ideal adder DUT with latency giving code=5 and N_TESTS=100 -> o_done=1, o_test_count=100, o_err_count=0, o_pass=1.
REQ-036 SHALL be verified for: same DUT with output bit 0 forced to 1 -> o_err_count>0, o_pass=0, o_first_err equal to the first corrupted value.
REQ-037 SHALL be verified for: i_dut_delay held at 15 (K=4) -> FSM stays in IDLE, o_test_count stays 0.
REQ-038 SHALL be verified for: operands 0xFFFFFFFF + 0x00000001 -> expected 0x00000000 with no error, and zero marker vectors are not counted.
REQ-039 SHALL be verified for: reset_n pulsed low for 1 cycle at test 50 -> all outputs 0 immediately, then a new run completes with o_test_count=100.
REQ-040 SHALL be verified for: MONITOR_STOP_ON_ERR_EN defined with one corrupted result -> o_err_count=1 and o_done asserted 2 cycles after the mismatch.
